demux8_buf: RTL and testbench

Single-stream to eight-channel demultiplexer with one registered holding slot per channel. It is the distribution-side counterpart of the 8:1 selectors in the datapath. One producer presents a word plus a 3-bit channel select, and the block steers the word into the selected channel's slot. Each of the eight consumers drains its slot independently with a valid/ready handshake. The block sits between a shared result source (e.g. a memory response path) and up to eight independent sinks.

---
 rtl/demux8_pkg.sv | 22 ++
 rtl/demux8_buf_slot.sv | 37 +++
 rtl/demux8_buf.sv | 80 ++++++++
 tb/tb_demux8_buf.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux8_pkg.sv
// Shared definitions for the eight-channel demultiplexer.
//   chan_sel_t : 3-bit channel select
//   NUM_CHAN   : number of output channels
//   CNT_W      : width of the occupancy count (holds 0..8)
//   count_ones : population count of a channel mask
package demux8_pkg;

  typedef logic [2:0] chan_sel_t;

  localparam int NUM_CHAN = 8;
  localparam int CNT_W    = 4;

  function automatic logic [CNT_W-1:0] count_ones(input logic [NUM_CHAN-1:0] v);
    logic [CNT_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      sum = sum + CNT_W'(v[i]);
    end
    return sum;
  endfunction

endpackage

// File: rtl/demux8_buf_slot.sv
// One-entry holding slot (EMPTY/FULL) for a single demux channel.
// Ports:
//   clk, rst : rising-edge clock, synchronous active-high reset
//   wr       : load wdata this cycle (takes priority, so write+drain stays FULL)
//   rd       : consumer takes the word this cycle
//   wdata    : word to load
//   valid    : slot is FULL
//   rdata    : slot contents; holds the last word while EMPTY
module slot_reg #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             rd,
  input  logic [width-1:0] wdata,
  output logic             valid,
  output logic [width-1:0] rdata
);

  // NOTE: state is updated with non-blocking assignments so every slot
  // samples the same pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      // NOTE: the data register is reset too, so out_data reads zero out of
      // reset; a drain alone never clears it.
      rdata <= '0;
    end else if (wr) begin
      valid <= 1'b1;
      rdata <= wdata;
    end else if (rd) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux8_buf.sv
// Single-stream to eight-channel demultiplexer with one registered slot per
// channel. The producer word is steered into slot in_sel; each consumer
// drains its own slot with a valid/ready handshake.
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   in_valid   : producer has a word
//   in_ready   : word accepted when in_valid && in_ready (combinational)
//   in_sel     : destination channel 0..7
//   in_data    : word to deliver
//   out_valid  : bit i set while slot i is FULL
//   out_ready  : bit i, consumer i takes slot i this cycle
//   out_data   : slot contents, element i valid while out_valid[i]
//   occupied   : registered count of FULL slots, 0..8
module demux8_buf
  import demux8_pkg::*;
#(
  parameter int width = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_sel,
  input  logic [width-1:0]      in_data,
  output logic [7:0]            out_valid,
  input  logic [7:0]            out_ready,
  output logic [7:0][width-1:0] out_data,
  output logic [CNT_W-1:0]      occupied
);

  chan_sel_t           sel;
  logic                accept;
  logic [NUM_CHAN-1:0] wr_vec;
  logic [NUM_CHAN-1:0] drain;
  logic [CNT_W-1:0]    inc;
  logic [CNT_W-1:0]    dec;

  assign sel = in_sel;

  // A full slot accepts a new word only when its consumer drains it in the
  // same cycle; in_valid deliberately plays no part here.
  assign in_ready = !out_valid[sel] || out_ready[sel];
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid & out_ready;

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wr_vec = '0;
    if (accept) begin
      wr_vec[sel] = 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CHAN; i++) begin : g_slot
    slot_reg #(.width(width)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .wr    (wr_vec[i]),
      .rd    (out_ready[i]),
      .wdata (in_data),
      .valid (out_valid[i]),
      .rdata (out_data[i])
    );
  end

  // A refill of a draining slot is net zero, so it neither increments nor
  // counts as a drain.
  assign inc = CNT_W'(accept && !out_valid[sel]);
  assign dec = count_ones(drain & ~wr_vec);

  always_ff @(posedge clk) begin
    if (rst) begin
      occupied <= '0;
    end else begin
      occupied <= occupied + inc - dec;
    end
  end

endmodule

// File: tb/tb_demux8_buf.sv
// Self-checking bench for demux8_buf: directed vectors with hand-computed
// expectations, followed by a randomised run against a per-channel slot
// scoreboard.
module tb_demux8_buf;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_sel;
  logic [15:0]      in_data;
  logic [7:0]       out_valid;
  logic [7:0]       out_ready;
  logic [7:0][15:0] out_data;
  logic [3:0]       occupied;

  int n_cmp;
  int n_bad;

  demux8_buf #(.width(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupied  (occupied)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard state for the random phase
  logic [7:0]  m_valid;
  logic [15:0] m_data [8];
  int          sent [8];
  int          rcvd [8];

  initial begin
    logic exp_rdy;
    logic acc;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_sel = '0;
    in_data = '0;
    out_ready = '0;

    // Reset state
    tick();
    tick();
    check("rst_out_valid", out_valid, 8'h00);
    check("rst_occupied", occupied, 0);
    for (int i = 0; i < 8; i++) check($sformatf("rst_out_data%0d", i), out_data[i], 16'h0);
    check("rst_in_ready", in_ready, 1);

    // Single write to channel 5
    rst = 1'b0;
    in_valid = 1'b1;
    in_sel = 3'd5;
    in_data = 16'hBEEF;
    tick();
    in_valid = 1'b0;
    check("wr_out_valid", out_valid, 8'h20);
    check("wr_out_data5", out_data[5], 16'hBEEF);
    check("wr_occupied", occupied, 1);
    for (int s = 0; s < 8; s++) begin
      if (s != 5) begin
        in_sel = 3'(s);
        #1;
        check($sformatf("wr_in_ready_sel%0d", s), in_ready, 1);
      end
    end

    // Backpressure on full slot 5
    in_valid = 1'b1;
    in_sel = 3'd5;
    in_data = 16'h1234;
    #1;
    check("bp_in_ready_low", in_ready, 0);
    tick();
    check("bp_keep_data5", out_data[5], 16'hBEEF);
    check("bp_keep_valid", out_valid, 8'h20);
    out_ready = 8'h20;
    #1;
    check("bp_in_ready_high", in_ready, 1);
    tick();
    in_valid = 1'b0;
    out_ready = 8'h00;
    check("bp_new_data5", out_data[5], 16'h1234);
    check("bp_occupied", occupied, 1);
    check("bp_out_valid", out_valid, 8'h20);

    // Drain slot 5, then fill all eight channels
    out_ready = 8'h20;
    tick();
    out_ready = 8'h00;
    check("drain5_occupied", occupied, 0);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_sel = 3'(i);
      in_data = 16'(i);
      tick();
    end
    in_valid = 1'b0;
    check("fill_out_valid", out_valid, 8'hFF);
    check("fill_occupied", occupied, 8);
    for (int i = 0; i < 8; i++) begin
      in_sel = 3'(i);
      #1;
      check($sformatf("fill_in_ready_sel%0d", i), in_ready, 0);
      check($sformatf("fill_out_data%0d", i), out_data[i], 16'(i));
    end

    // Parallel drain of 0..3 while refilling channel 2
    out_ready = 8'h0F;
    in_valid = 1'b1;
    in_sel = 3'd2;
    in_data = 16'hAAAA;
    tick();
    in_valid = 1'b0;
    out_ready = 8'h00;
    check("par_out_valid", out_valid, 8'hF4);
    check("par_out_data2", out_data[2], 16'hAAAA);
    check("par_occupied", occupied, 5);
    check("par_out_data4", out_data[4], 16'h0004);

    // Leave three slots full (2, 6, 7), then reset during a write
    out_ready = 8'h30;
    tick();
    out_ready = 8'h00;
    check("pre_rst_out_valid", out_valid, 8'hC4);
    check("pre_rst_occupied", occupied, 3);
    rst = 1'b1;
    in_valid = 1'b1;
    in_sel = 3'd0;
    in_data = 16'h5555;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("mid_rst_out_valid", out_valid, 8'h00);
    check("mid_rst_occupied", occupied, 0);
    for (int i = 0; i < 8; i++) check($sformatf("mid_rst_out_data%0d", i), out_data[i], 16'h0);

    // Randomised run against the slot scoreboard
    m_valid = '0;
    for (int i = 0; i < 8; i++) begin
      m_data[i] = '0;
      sent[i] = 0;
      rcvd[i] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check("rnd_out_valid", out_valid, m_valid);
      check("rnd_occupied", occupied, $countones(m_valid));
      in_valid = ($urandom_range(0, 3) != 0);
      in_sel = 3'($urandom_range(0, 7));
      in_data = 16'($urandom);
      out_ready = 8'($urandom);
      #1;
      exp_rdy = !m_valid[in_sel] || out_ready[in_sel];
      check("rnd_in_ready", in_ready, exp_rdy);
      for (int i = 0; i < 8; i++) begin
        if (m_valid[i] && out_ready[i]) begin
          check($sformatf("rnd_out_data%0d", i), out_data[i], m_data[i]);
          rcvd[i]++;
          m_valid[i] = 1'b0;
        end
      end
      acc = in_valid && exp_rdy;
      if (acc) begin
        m_valid[in_sel] = 1'b1;
        m_data[in_sel] = in_data;
        sent[in_sel]++;
      end
      tick();
    end
    // Final drain: every word sent must have been delivered exactly once
    in_valid = 1'b0;
    out_ready = 8'hFF;
    #1;
    for (int i = 0; i < 8; i++) begin
      if (m_valid[i]) begin
        check($sformatf("end_out_data%0d", i), out_data[i], m_data[i]);
        rcvd[i]++;
      end
    end
    tick();
    out_ready = 8'h00;
    check("end_out_valid", out_valid, 8'h00);
    check("end_occupied", occupied, 0);
    for (int i = 0; i < 8; i++) check($sformatf("end_count%0d", i), rcvd[i], sent[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
